ram_stream_reader: RTL and testbench

//  Read-side controller for the inferred simple-dual-port RAMs (1024x8 class):

---
 rtl/ram_rd_pkg.sv | 19 +
 rtl/ram_rd_skid.sv | 71 +++++++
 rtl/ram_stream_reader.sv | 141 ++++++++++++++
 tb/tb_ram_stream_reader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ram_rd_pkg.sv
// Shared widths, FSM encoding and buffer sizing for the RAM stream reader.
package ram_rd_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 1024;

    // Output buffer depth and the width of its occupancy count.
    localparam int BUF_DEPTH  = 2;
    localparam int CNT_W      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry valid/ready buffer that captures RAM read data and presents the
// head entry as a registered stream beat; flush empties it in one cycle.
module ram_rd_skid
    import ram_rd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] entry0;
    logic [DATA_W-1:0] entry1;
    logic [CNT_W-1:0]  cnt;
    logic              pop;

    assign pop       = out_valid & out_ready;
    assign out_valid = (cnt != '0);
    assign out_data  = entry0;
    assign count     = cnt;

    // entry0 is always the head; a push never arrives into a full buffer
    // because the reader only issues a read when space is guaranteed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            cnt    <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (cnt)
                CNT_W'(0): begin
                    if (in_valid) begin
                        entry0 <= in_data;
                        cnt    <= CNT_W'(1);
                    end
                end
                CNT_W'(1): begin
                    if (pop && in_valid) begin
                        entry0 <= in_data;
                    end else if (pop) begin
                        cnt <= CNT_W'(0);
                    end else if (in_valid) begin
                        entry1 <= in_data;
                        cnt    <= CNT_W'(2);
                    end
                end
                CNT_W'(2): begin
                    if (pop) begin
                        entry0 <= entry1;
                        if (in_valid) begin
                            entry1 <= in_data;
                        end else begin
                            cnt <= CNT_W'(1);
                        end
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side RAM controller: issues credit-limited reads from base_addr and
// streams length bytes out over a valid/ready interface.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads while the buffer has room
// DRAIN | all reads issued, waiting for the last beat to be accepted
// DONE  | one-cycle completion pulse
module ram_stream_reader
    import ram_rd_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] ra,
    output logic              rclk_en,
    input  logic [DATA_W-1:0] rd,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    rd_state_t         state;
    rd_state_t         state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   issue_cnt;
    logic [ADDR_W:0]   accept_cnt;
    logic [ADDR_W:0]   accept_next;
    logic              in_flight;
    logic [CNT_W-1:0]  buf_count;
    logic [CNT_W:0]    pending;
    logic              pop;
    logic              credit_ok;
    logic              issue;
    logic              launch;
    logic              last_issue;

    assign pop         = m_valid & m_ready;
    assign launch      = (state == IDLE) && start && !abort;
    assign accept_next = accept_cnt + {{ADDR_W{1'b0}}, pop};
    assign last_issue  = ((issue_cnt + (ADDR_W+1)'(1)) == len_q);

    // Entries still held after this cycle's pop plus the word already on RD;
    // a new read is safe only if that leaves a free slot when its data lands.
    assign pending   = {1'b0, buf_count} - {{CNT_W{1'b0}}, pop}
                     + {{CNT_W{1'b0}}, in_flight};
    assign credit_ok = (pending < (CNT_W+1)'(BUF_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next = (length == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    issue = credit_ok;
                    if (credit_ok && last_issue) begin
                        state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept_next == len_q) begin
                        state_next = DONE;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            len_q      <= '0;
            issue_cnt  <= '0;
            accept_cnt <= '0;
            in_flight  <= 1'b0;
        end else begin
            in_flight <= issue;
            if (launch) begin
                addr_q     <= base_addr;
                len_q      <= length;
                issue_cnt  <= '0;
                accept_cnt <= '0;
            end else begin
                if (issue) begin
                    addr_q    <= (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                    issue_cnt <= issue_cnt + 1'b1;
                end
                if (pop) begin
                    accept_cnt <= accept_next;
                end
            end
        end
    end

    ram_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .in_data   (rd),
        .in_valid  (in_flight),
        .out_data  (m_data),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .count     (buf_count)
    );

    assign ra      = addr_q;
    assign rclk_en = issue;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader against a 1024x8 RAM model holding
// mem[i] = i[7:0]; cycle n counts negedges after the edge that samples start.
module tb_ram_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic [9:0]  ra;
    logic        rclk_en;
    logic [7:0]  rd;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        done;

    logic [7:0]  mem [1024];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rclk_en) rd <= mem[ra];
    end

    ram_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .length    (length),
        .ra        (ra),
        .rclk_en   (rclk_en),
        .rd        (rd),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: m_ready held high; mode 1: m_ready follows pat, LSB first.
    task automatic run_xfer(input int base, input int len, input int mode,
                            input int abort_beat, input int busy_start_n);
        logic [7:0] pat;
        logic [7:0] pdata;
        int issued, accepted, done_cnt, done_n, first_v, n, pend;
        bit fin, aborted, stall, vseen;
        pat = 8'b1010_1001;
        issued = 0; accepted = 0; done_cnt = 0; done_n = -1; first_v = -1;
        fin = 0; aborted = 0; stall = 0; vseen = 0; pdata = '0;
        @(negedge clk);
        base_addr = base[9:0];
        length    = len[10:0];
        start     = 1'b1;
        n = 0;
        while (!fin && n < 2000) begin
            @(negedge clk);
            start = (n == busy_start_n);
            if (start) begin
                base_addr = base_addr + 10'h100;
                length    = 11'd5;
            end
            abort   = 1'b0;
            m_ready = (mode == 1) ? pat[n % 8] : 1'b1;
            if (aborted) begin
                check_val("abort_valid", m_valid, 0);
                check_val("abort_busy", busy, 0);
                check_val("abort_done", done, 0);
                fin = 1;
            end else begin
                if (abort_beat >= 0 && accepted == abort_beat && m_valid) begin
                    m_ready = 1'b0;
                    abort   = 1'b1;
                    aborted = 1;
                end
                #1;
                if (stall) begin
                    check_val("hold_valid", m_valid, 1);
                    check_val("hold_data", m_data, pdata);
                end
                if (m_valid && first_v < 0) first_v = n;
                if (m_valid) vseen = 1;
                pend = issued - accepted - ((m_valid && m_ready) ? 1 : 0);
                if (rclk_en) begin
                    check_val("ra", ra, (base + issued) % 1024);
                    check_val("credit", (pend < 2), 1);
                    issued++;
                end
                if (m_valid && m_ready) begin
                    check_val("data", m_data, ((base + accepted) % 1024) % 256);
                    accepted++;
                end
                stall = m_valid && !m_ready;
                pdata = m_data;
                if (done) begin
                    done_cnt++;
                    if (done_n < 0) done_n = n;
                end
                if (done_n >= 0 && n == done_n + 1) begin
                    check_val("busy_after_done", busy, 0);
                    fin = 1;
                end
            end
            n++;
        end
        start = 1'b0;
        abort = 1'b0;
        if (!fin) check_val("timeout", 0, 1);
        if (aborted) begin
            check_val("abort_no_done", done_cnt, 0);
        end else begin
            check_val("beats", accepted, len);
            check_val("reads", issued, len);
            check_val("done_cnt", done_cnt, 1);
        end
        if (mode == 0 && len > 0 && !aborted) begin
            check_val("first_valid", first_v, 2);
            check_val("done_at", done_n, 2 + len);
        end
        if (len == 0) begin
            check_val("len0_valid", vseen, 0);
            check_val("len0_done_soon", (done_n >= 0 && done_n <= 1), 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
        rd        = '0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        m_ready   = 1'b1;
        base_addr = '0;
        length    = '0;
        repeat (3) @(negedge clk);
        check_val("rst_ra", ra, 0);
        check_val("rst_rclk_en", rclk_en, 0);
        check_val("rst_m_valid", m_valid, 0);
        check_val("rst_m_data", m_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_xfer(0, 4, 0, -1, -1);
        run_xfer(1022, 4, 0, -1, -1);
        check_val("ra_after_wrap", ra, 2);
        run_xfer(0, 8, 1, -1, 3);
        run_xfer(0, 0, 0, -1, 0);
        repeat (3) begin
            @(negedge clk);
            check_val("ignored_start_busy", busy, 0);
            check_val("ignored_start_rd", rclk_en, 0);
        end
        run_xfer(0, 16, 0, 4, -1);
        repeat (3) begin
            @(negedge clk);
            check_val("post_abort_done", done, 0);
            check_val("post_abort_valid", m_valid, 0);
        end
        run_xfer(16, 2, 0, -1, -1);
        run_xfer(0, 1024, 0, -1, -1);
        check_val("full_wrap_ra", ra, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
